// File: rtl/bcd_serial_add_ctrl_if.sv
// bcd_serial_add_ctrl_if: request/result bundle between a front end and the digit-serial BCD adder
interface bcd_serial_add_ctrl_if #(parameter int DIGITS = 4);
  logic start;
  logic [4*DIGITS-1:0] augend;
  logic [4*DIGITS-1:0] addend;
  logic cin;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] sum;
  logic cout;
  logic err;
  modport master(output start, augend, addend, cin, input busy, done, sum, cout, err);
  modport slave(input start, augend, addend, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: one shared BCD digit adder sequenced LSD-first across DIGITS digits
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst_n,
  bcd_serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a_sr, b_sr, sum_r;
  logic carry, cout_r, err_r, c_nx, last, accept;
  logic [CNT_W-1:0] cnt;
  logic [3:0] a, b, digit;
  logic [4:0] t;
  always_comb begin
    a = a_sr[3:0];
    b = b_sr[3:0];
    t = 5'(a) + 5'(b) + 5'(carry);
    c_nx = t > 5'd9;
    digit = c_nx ? t[3:0] + 4'd6 : t[3:0];
    last = cnt == CNT_W'(DIGITS - 1);
    accept = bus.start && state != RUN;
    state_nx = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Digits enter sum from the top so digit 0 lands in [3:0] after DIGITS shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      cout_r <= 1'b0;
      err_r <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      a_sr <= bus.augend;
      b_sr <= bus.addend;
      carry <= bus.cin;
      sum_r <= '0;
      cout_r <= 1'b0;
      err_r <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 4;
      b_sr <= b_sr >> 4;
      carry <= c_nx;
      sum_r <= (sum_r >> 4) | (W'(digit) << (W - 4));
      err_r <= err_r | (a > 4'd9) | (b > 4'd9);
      cnt <= cnt + 1'b1;
      if (last) cout_r <= c_nx;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
  assign bus.err = err_r;
endmodule
